// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion and MEM/WB operand forwarding.
// Latency: 1 cycle from the id_valid/id_ready handshake to ex_valid; forwarding onto ex_rs1/ex_rs2 is combinational.
// Backpressure: holds its instruction while ex_ready=0; id_ready drops on hold, load-use hazard or flush.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_*                decoded instruction from decode; id_ready is the accept strobe
//   flush               kills the held instruction and the incoming one
//   ex_ready            downstream consumes ex_valid this cycle
//   mem_*, wb_*         destination/enable/result of the MEM and WB stages, used for forwarding
//   ex_*                held instruction; ex_rs1/ex_rs2 carry the forwarded operands
// Optional: define ID_EX_PERF_CNT_EN to add the stall_cnt/bubble_cnt performance counters.
module id_ex_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] id_rs1_idx,
    input  logic [REG_AW-1:0] id_rs2_idx,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [XLEN-1:0]   id_rs1_val,
    input  logic [XLEN-1:0]   id_rs2_val,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [5:0]        id_alu_control,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [XLEN-1:0]   wb_result,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_rs1,
    output logic [XLEN-1:0]   ex_rs2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [5:0]        ex_alu_control,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    // Held operand state; the source indices are kept so forwarding and the
    // WB refresh can match against them after capture.
    logic [REG_AW-1:0] rs1_idx_q, rs2_idx_q;
    logic [XLEN-1:0]   rs1_val_q, rs2_val_q;

    logic load;
    logic hazard;
    logic capture;
    logic hold;
    logic wb_hit_id_rs1, wb_hit_id_rs2;
    logic wb_hit_rs1_q, wb_hit_rs2_q;

    // Stage may take a new instruction when empty or when the held one leaves.
    assign load = !ex_valid || ex_ready;

    // Load-use: the held load's data is not available until after MEM, so a
    // dependent instruction must wait one cycle behind a bubble.
    assign hazard = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                    ((id_use_rs1 && (id_rs1_idx == ex_rd)) ||
                     (id_use_rs2 && (id_rs2_idx == ex_rd)));

    assign id_ready = load && !hazard && !flush;
    assign capture  = id_valid && id_ready;
    assign hold     = ex_valid && !ex_ready;

    // WB writes the register file in the same cycle decode reads it, so the
    // read data may be stale; take the WB result directly.
    assign wb_hit_id_rs1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1_idx);
    assign wb_hit_id_rs2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2_idx);

    // A producer retiring through WB while we are stalled would otherwise be
    // lost once it leaves the forwarding window.
    assign wb_hit_rs1_q = wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_idx_q);
    assign wb_hit_rs2_q = wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            rs1_idx_q      <= '0;
            rs2_idx_q      <= '0;
            rs1_val_q      <= '0;
            rs2_val_q      <= '0;
            ex_imm         <= '0;
            ex_alu_control <= '0;
            ex_rd          <= '0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
        end else begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (load && hazard) begin
                ex_valid <= 1'b0;
            end else if (load) begin
                ex_valid <= id_valid;
            end

            if (capture) begin
                rs1_idx_q      <= id_rs1_idx;
                rs2_idx_q      <= id_rs2_idx;
                rs1_val_q      <= wb_hit_id_rs1 ? wb_result : id_rs1_val;
                rs2_val_q      <= wb_hit_id_rs2 ? wb_result : id_rs2_val;
                ex_imm         <= id_imm;
                ex_alu_control <= id_alu_control;
                ex_rd          <= id_rd;
                ex_reg_write   <= id_reg_write;
                ex_mem_read    <= id_mem_read;
            end else if (hold) begin
                if (wb_hit_rs1_q) rs1_val_q <= wb_result;
                if (wb_hit_rs2_q) rs2_val_q <= wb_result;
            end
        end
    end

    // MEM is the younger producer, so it takes priority over WB; x0 never forwards.
    always_comb begin
        ex_rs1 = rs1_val_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs1_idx_q)) begin
            ex_rs1 = mem_result;
        end else if (wb_hit_rs1_q) begin
            ex_rs1 = wb_result;
        end

        ex_rs2 = rs2_val_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs2_idx_q)) begin
            ex_rs2 = mem_result;
        end else if (wb_hit_rs2_q) begin
            ex_rs2 = wb_result;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (hazard)    stall_cnt  <= stall_cnt + 32'd1;
            if (!ex_valid) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by randomized traffic against a transaction-level model.
// Latency: checks are taken at the falling edge, one cycle after each handshake.
// Backpressure: ex_ready and flush are driven randomly to exercise hold, refresh and bubble paths.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1_idx, id_rs2_idx;
    logic        id_use_rs1, id_use_rs2;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm;
    logic [5:0]  id_alu_control;
    logic [4:0]  id_rd;
    logic        id_reg_write, id_mem_read;
    logic        flush, ex_ready;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid;
    logic [31:0] ex_rs1, ex_rs2, ex_imm;
    logic [5:0]  ex_alu_control;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_alu_control(id_alu_control),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .ex_ready(ex_ready),
        .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_result(mem_result), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_alu_control(ex_alu_control), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs1_idx = '0; id_rs2_idx = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rs1_val = '0; id_rs2_val = '0; id_imm = '0; id_alu_control = '0;
        id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        flush = 1'b0; ex_ready = 1'b1;
        mem_rd = '0; wb_rd = '0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        mem_result = '0; wb_result = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic u1, input logic [31:0] v1,
                         input logic [4:0] rs2, input logic u2, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [5:0] alu,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = 1'b1;
        id_rs1_idx = rs1; id_use_rs1 = u1; id_rs1_val = v1;
        id_rs2_idx = rs2; id_use_rs2 = u2; id_rs2_val = v2;
        id_imm = imm; id_alu_control = alu; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr;
    endtask

    // Reference model: the stage is a one-entry slot holding a decoded instruction.
    typedef struct packed {
        logic            v;
        logic [1:0][4:0] idx;
        logic [1:0][31:0] val;
        logic [31:0]     imm;
        logic [5:0]      alu;
        logic [4:0]      rd;
        logic            rw;
        logic            mr;
    } slot_t;

    slot_t m;

    function automatic logic wb_writes(input logic [4:0] r);
        return wb_reg_write && r != 5'd0 && wb_rd == r;
    endfunction

    function automatic logic [31:0] operand_seen(input logic [4:0] r, input logic [31:0] held);
        if (r == 5'd0) return held;
        if (mem_reg_write && mem_rd == r) return mem_result;
        if (wb_reg_write && wb_rd == r) return wb_result;
        return held;
    endfunction

    task automatic random_cycle();
        logic        dep;
        logic        exp_rdy;
        slot_t       nxt;
        logic [4:0]  src [2];
        logic [31:0] rf  [2];
        id_valid       = ($urandom_range(0, 3) != 0);
        id_rs1_idx     = 5'($urandom_range(0, 3));
        id_rs2_idx     = 5'($urandom_range(0, 3));
        id_use_rs1     = 1'($urandom_range(0, 1));
        id_use_rs2     = 1'($urandom_range(0, 1));
        id_rs1_val     = $urandom();
        id_rs2_val     = $urandom();
        id_imm         = $urandom();
        id_alu_control = 6'($urandom_range(0, 63));
        id_rd          = 5'($urandom_range(0, 3));
        id_reg_write   = 1'($urandom_range(0, 1));
        id_mem_read    = ($urandom_range(0, 2) == 0);
        flush          = ($urandom_range(0, 9) == 0);
        ex_ready       = ($urandom_range(0, 3) != 0);
        mem_rd         = 5'($urandom_range(0, 3));
        wb_rd          = 5'($urandom_range(0, 3));
        mem_reg_write  = 1'($urandom_range(0, 1));
        wb_reg_write   = 1'($urandom_range(0, 1));
        mem_result     = $urandom();
        wb_result      = $urandom();

        @(negedge clk);
        dep = id_valid && m.v && m.mr && m.rd != 5'd0 &&
              ((id_use_rs1 && id_rs1_idx == m.rd) || (id_use_rs2 && id_rs2_idx == m.rd));
        exp_rdy = (!m.v || ex_ready) && !dep && !flush;
        check("rnd_id_ready", 32'(id_ready), 32'(exp_rdy));
        check("rnd_ex_valid", 32'(ex_valid), 32'(m.v));
        if (m.v) begin
            check("rnd_ex_rs1", ex_rs1, operand_seen(m.idx[0], m.val[0]));
            check("rnd_ex_rs2", ex_rs2, operand_seen(m.idx[1], m.val[1]));
            check("rnd_ex_imm", ex_imm, m.imm);
            check("rnd_ex_ctl", {19'd0, ex_alu_control, ex_rd, ex_reg_write, ex_mem_read},
                  {19'd0, m.alu, m.rd, m.rw, m.mr});
        end

        nxt = m;
        if (m.v && !ex_ready) begin
            for (int k = 0; k < 2; k++)
                if (wb_writes(m.idx[k])) nxt.val[k] = wb_result;
        end
        if (id_valid && exp_rdy) begin
            src[0] = id_rs1_idx; src[1] = id_rs2_idx;
            rf[0]  = id_rs1_val; rf[1]  = id_rs2_val;
            nxt.v = 1'b1;
            for (int k = 0; k < 2; k++) begin
                nxt.idx[k] = src[k];
                nxt.val[k] = wb_writes(src[k]) ? wb_result : rf[k];
            end
            nxt.imm = id_imm; nxt.alu = id_alu_control; nxt.rd = id_rd;
            nxt.rw = id_reg_write; nxt.mr = id_mem_read;
        end else begin
            // An instruction survives only if it was there, was not taken and was not killed.
            nxt.v = m.v && !ex_ready && !flush;
        end
        m = nxt;
        tick();
    endtask

    initial begin
        idle();
        #12;
        // Reset state
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_ex_rs1", ex_rs1, 32'd0);
        check("rst_ex_imm", ex_imm, 32'd0);
        check("rst_id_ready", 32'(id_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back: addi x1,x0,5 then add x2,x1,x1 with MEM forwarding x1=5
        issue(5'd0, 1'b1, 32'd0, 5'd0, 1'b0, 32'd0, 32'd5, 6'h01, 5'd1, 1'b1, 1'b0);
        tick();
        issue(5'd1, 1'b1, 32'h111, 5'd1, 1'b1, 32'h111, 32'd0, 6'h02, 5'd2, 1'b1, 1'b0);
        @(negedge clk);
        check("b2b_addi_imm", ex_imm, 32'd5);
        tick();
        id_valid = 1'b0;
        mem_reg_write = 1'b1; mem_rd = 5'd1; mem_result = 32'd5;
        @(negedge clk);
        check("b2b_ex_rs1", ex_rs1, 32'd5);
        check("b2b_ex_rs2", ex_rs2, 32'd5);
        check("b2b_ex_rd", 32'(ex_rd), 32'd2);
        tick();
        idle();

        // Load-use: lw x3 held, dependent reads rs1=x3
        issue(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 6'h03, 5'd3, 1'b1, 1'b1);
        tick();
        issue(5'd3, 1'b1, 32'h5, 5'd0, 1'b0, 32'd0, 32'd0, 6'h04, 5'd6, 1'b1, 1'b0);
        @(negedge clk);
        check("lu_id_ready_stall", 32'(id_ready), 32'd0);
        tick();
        @(negedge clk);
        check("lu_bubble", 32'(ex_valid), 32'd0);
        check("lu_id_ready_after", 32'(id_ready), 32'd1);
        tick();
        @(negedge clk);
        check("lu_capture_valid", 32'(ex_valid), 32'd1);
        check("lu_capture_rd", 32'(ex_rd), 32'd6);
        tick();
        idle();

        // Downstream stall with WB refresh of held rs2=x4
        issue(5'd0, 1'b0, 32'd0, 5'd4, 1'b1, 32'h1234, 32'd0, 6'h05, 5'd7, 1'b1, 1'b0);
        tick();
        idle();
        ex_ready = 1'b0;
        @(negedge clk);
        check("stall_id_ready", 32'(id_ready), 32'd0);
        tick();
        wb_reg_write = 1'b1; wb_rd = 5'd4; wb_result = 32'hDEADBEEF;
        tick();
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
        tick();
        ex_ready = 1'b1;
        @(negedge clk);
        check("stall_ex_valid", 32'(ex_valid), 32'd1);
        check("stall_ex_rs2", ex_rs2, 32'hDEADBEEF);
        tick();

        // Flush with both held and incoming instructions
        issue(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'h99, 6'h06, 5'd8, 1'b1, 1'b0);
        tick();
        issue(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'h77, 6'h07, 5'd9, 1'b1, 1'b0);
        flush = 1'b1; ex_ready = 1'b0;
        @(negedge clk);
        check("flush_id_ready", 32'(id_ready), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("flush_ex_valid", 32'(ex_valid), 32'd0);
        tick();

        // x0 guard and MEM-over-WB priority
        issue(5'd0, 1'b1, 32'd0, 5'd5, 1'b1, 32'h55, 32'd0, 6'h08, 5'd9, 1'b1, 1'b0);
        tick();
        idle();
        ex_ready = 1'b0;
        mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'd7;
        @(negedge clk);
        check("x0_ex_rs1", ex_rs1, 32'd0);
        mem_rd = 5'd5; mem_result = 32'hAAAA;
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'hBBBB;
        #1;
        check("prio_ex_rs2", ex_rs2, 32'hAAAA);
        tick();
        idle();
        ex_ready = 1'b0;
        @(negedge clk);
        check("refresh_ex_rs2", ex_rs2, 32'hBBBB);
        tick();
        ex_ready = 1'b1;
        tick();

        // Asynchronous reset while holding a valid instruction
        issue(5'd2, 1'b1, 32'hCAFE, 5'd3, 1'b1, 32'hF00D, 32'h1234, 6'h2A, 5'd10, 1'b1, 1'b1);
        tick();
        idle();
        ex_ready = 1'b0;
        #2;
        check("arst_pre_valid", 32'(ex_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_ex_valid", 32'(ex_valid), 32'd0);
        check("arst_ex_imm", ex_imm, 32'd0);
        check("arst_ex_ctl", {19'd0, ex_alu_control, ex_rd, ex_reg_write, ex_mem_read}, 32'd0);
        check("arst_ex_rs", ex_rs1 | ex_rs2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the slot model
        m = '0;
        tick();
        for (int i = 0; i < 3000; i++) random_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
